// File: rtl/ct_split_pkg.sv
// Shared definitions for the ct_split / ct_merge interconnect blocks:
// packet-tracking state encoding and a width helper.
package ct_split_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } pkt_state_e;

  // Number of bits needed to index n distinct items (minimum 1).
  function automatic int nibits(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ct_split.sv
// One-to-NO packet-aware splitter: one registered stage, 1-cycle latency; accepts only when
// every pending output drains this cycle, so one stalled output blocks all (head-of-line).
module ct_split
  import ct_split_pkg::*;
#(
  parameter int NO      = 2,
  parameter int WIDTH   = 8,
  parameter int EOP_LOC = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    i_data,
  input  logic                i_valid,
  input  logic [NO-1:0]       i_mask,
  output logic                o_ready,
  output logic [NO*WIDTH-1:0] o_data,
  output logic [NO-1:0]       o_valid,
  input  logic [NO-1:0]       i_ready
);

  logic [NO-1:0]    pending_q, pending_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [NO-1:0]    route_q, route_d;
  pkt_state_e       state_q, state_d;
  logic             accept;
  logic [NO-1:0]    eff_mask;

  assign o_ready = ((pending_q & ~i_ready) == '0);
  assign o_valid = pending_q;
  assign o_data  = {NO{data_q}};

  always_comb begin
    accept    = o_ready && i_valid;
    eff_mask  = (state_q == PKT) ? route_q : i_mask;
    pending_d = pending_q & ~i_ready;
    data_d    = data_q;
    route_d   = route_q;
    state_d   = state_q;
    // A new load replaces whatever the drain left behind in the same cycle.
    if (accept) begin
      pending_d = eff_mask;
      data_d    = i_data;
      if (state_q == IDLE) begin
        if (!i_data[EOP_LOC]) begin
          route_d = i_mask;
          state_d = PKT;
        end
      end else if (i_data[EOP_LOC]) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      data_q    <= '0;
      route_q   <= '0;
      state_q   <= IDLE;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
      route_q   <= route_d;
      state_q   <= state_d;
    end
  end

endmodule
